// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU request arbiter: opcode values, controller states,
// flag bit positions inside {z,n,c,v} and the opcode-legality decode.
package alu_ctrl_pkg;

   localparam int OP_W = 5;

   localparam logic [OP_W-1:0] OP_NOP = 5'h00;
   localparam logic [OP_W-1:0] OP_LD  = 5'h01;
   localparam logic [OP_W-1:0] OP_ADD = 5'h03;
   localparam logic [OP_W-1:0] OP_SUB = 5'h04;
   localparam logic [OP_W-1:0] OP_AND = 5'h05;
   localparam logic [OP_W-1:0] OP_OR  = 5'h06;
   localparam logic [OP_W-1:0] OP_XOR = 5'h07;
   localparam logic [OP_W-1:0] OP_NOT = 5'h08;
   localparam logic [OP_W-1:0] OP_SL  = 5'h09;
   localparam logic [OP_W-1:0] OP_SR  = 5'h0A;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      logic legal_s;
      case (op)
         OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_XOR, OP_NOT, OP_SL, OP_SR: legal_s = 1'b1;
         default:                      legal_s = 1'b0;
      endcase
      return legal_s;
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins; on a tie the port
// that was not served last wins.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last,
   output logic [1:0] grant
);

   // One-hot grant decode
   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Front end that shares one combinational ALU between two requesters: one op in
// flight, operands latched on accept, result/flags registered until the owner takes them.
import alu_ctrl_pkg::*;

module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int OPW   = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*WIDTH-1:0] req_a,
   input  logic [2*WIDTH-1:0] req_b,
   input  logic [2*OPW-1:0]   req_op,
   output logic [1:0]         rsp_valid,
   input  logic [1:0]         rsp_ready,
   output logic [WIDTH-1:0]   rsp_result,
   output logic [3:0]         rsp_flags,
   output logic               rsp_err,
   output logic [WIDTH-1:0]   alu_busA,
   output logic [WIDTH-1:0]   alu_busB,
   output logic [OPW-1:0]     alu_operation,
   input  logic [WIDTH-1:0]   alu_result,
   input  logic [3:0]         alu_flags,
   output logic [15:0]        ops_done
);

   state_e           state_r;
   state_e           state_next_s;
   logic [1:0]       grant_s;
   logic             last_grant_r;
   logic             owner_r;
   logic             err_r;
   logic             accept_s;
   logic             rsp_take_s;
   logic             legal_s;
   logic [WIDTH-1:0] a_sel_s;
   logic [WIDTH-1:0] b_sel_s;
   logic [OPW-1:0]   op_sel_s;
   logic [3:0]       flags_cap_s;
   logic [1:0]       req_ready_s;
   logic [WIDTH-1:0] bus_a_r;
   logic [WIDTH-1:0] bus_b_r;
   logic [OPW-1:0]   alu_op_r;
   logic [1:0]       rsp_valid_r;
   logic [WIDTH-1:0] rsp_result_r;
   logic [3:0]       rsp_flags_r;
   logic             rsp_err_r;
   logic [15:0]      ops_done_r;

   rr_arb2 u_rr_arb2 (
      .valid (req_valid),
      .last  (last_grant_r),
      .grant (grant_s)
   );

   assign accept_s   = (state_r == ST_IDLE) && (grant_s != 2'b00);
   assign rsp_take_s = (state_r == ST_RESP) && rsp_ready[owner_r];
   assign legal_s    = is_legal_op(OP_W'(op_sel_s));

   // Steer the granted port's operands toward the latch
   always_comb begin
      a_sel_s  = req_a[WIDTH-1:0];
      b_sel_s  = req_b[WIDTH-1:0];
      op_sel_s = req_op[OPW-1:0];
      if (grant_s[1]) begin
         a_sel_s  = req_a[2*WIDTH-1:WIDTH];
         b_sel_s  = req_b[2*WIDTH-1:WIDTH];
         op_sel_s = req_op[2*OPW-1:OPW];
      end else begin
         a_sel_s  = req_a[WIDTH-1:0];
         b_sel_s  = req_b[WIDTH-1:0];
         op_sel_s = req_op[OPW-1:0];
      end
   end

   // Flags captured at the end of EXEC; an illegal op reports all-zero flags
   always_comb begin
      flags_cap_s = 4'b0000;
      if (!err_r) begin
         flags_cap_s[FLAG_Z] = alu_flags[FLAG_Z];
         flags_cap_s[FLAG_N] = alu_flags[FLAG_N];
         flags_cap_s[FLAG_C] = alu_flags[FLAG_C];
         flags_cap_s[FLAG_V] = alu_flags[FLAG_V];
      end else begin
         flags_cap_s = 4'b0000;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_next_s = ST_EXEC;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_EXEC: state_next_s = ST_RESP;
         ST_RESP: begin
            if (rsp_take_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_RESP;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // FSM outputs: ready must answer valid in the same cycle, so it stays combinational
   always_comb begin
      req_ready_s = 2'b00;
      if (state_r == ST_IDLE) begin
         req_ready_s = grant_s;
      end else begin
         req_ready_s = 2'b00;
      end
   end

   // Operand latch and ALU opcode drive; the opcode is only non-zero during EXEC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_a_r  <= '0;
         bus_b_r  <= '0;
         alu_op_r <= '0;
         owner_r  <= 1'b0;
         err_r    <= 1'b0;
      end else if (accept_s) begin
         bus_a_r  <= a_sel_s;
         bus_b_r  <= b_sel_s;
         alu_op_r <= legal_s ? op_sel_s : '0;
         owner_r  <= grant_s[1];
         err_r    <= ~legal_s;
      end else if (state_r == ST_EXEC) begin
         alu_op_r <= '0;
      end
   end

   // Response registers: loaded at the close of EXEC, held until the owner accepts
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_r  <= 2'b00;
         rsp_result_r <= '0;
         rsp_flags_r  <= 4'b0000;
         rsp_err_r    <= 1'b0;
      end else if (state_r == ST_EXEC) begin
         rsp_valid_r  <= owner_r ? 2'b10 : 2'b01;
         rsp_result_r <= err_r ? '0 : alu_result;
         rsp_flags_r  <= flags_cap_s;
         rsp_err_r    <= err_r;
      end else if (rsp_take_s) begin
         rsp_valid_r  <= 2'b00;
      end
   end

   // Completion counter and round-robin history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ops_done_r   <= 16'd0;
         last_grant_r <= 1'b1;
      end else if (rsp_take_s) begin
         ops_done_r   <= ops_done_r + 16'd1;
         last_grant_r <= owner_r;
      end
   end

   assign req_ready     = req_ready_s;
   assign rsp_valid     = rsp_valid_r;
   assign rsp_result    = rsp_result_r;
   assign rsp_flags     = rsp_flags_r;
   assign rsp_err       = rsp_err_r;
   assign alu_busA      = bus_a_r;
   assign alu_busB      = bus_b_r;
   assign alu_operation = alu_op_r;
   assign ops_done      = ops_done_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the alu_* side.
module tb_alu_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [9:0]  req_op;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags;
   logic        rsp_err;
   logic [31:0] alu_busA;
   logic [31:0] alu_busB;
   logic [4:0]  alu_operation;
   logic [31:0] alu_result;
   logic [3:0]  alu_flags;
   logic [15:0] ops_done;

   int checks = 0;
   int errors = 0;

   logic [32:0] alu_t;
   logic [31:0] alu_res;
   logic        alu_c;
   logic        alu_v;
   logic        alu_known;

   alu_arbiter #(.WIDTH(32), .OPW(5)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_a         (req_a),
      .req_b         (req_b),
      .req_op        (req_op),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_result    (rsp_result),
      .rsp_flags     (rsp_flags),
      .rsp_err       (rsp_err),
      .alu_busA      (alu_busA),
      .alu_busB      (alu_busB),
      .alu_operation (alu_operation),
      .alu_result    (alu_result),
      .alu_flags     (alu_flags),
      .ops_done      (ops_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU; unknown opcodes return a garbage pattern so leaks are visible
   always_comb begin
      alu_t = 33'd0;
      alu_res = 32'd0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      alu_known = 1'b1;
      case (alu_operation)
         5'h01: alu_res = alu_busB;
         5'h03: begin
            alu_t = {1'b0, alu_busA} + {1'b0, alu_busB};
            alu_res = alu_t[31:0];
            alu_c = alu_t[32];
            alu_v = (alu_busA[31] == alu_busB[31]) && (alu_res[31] != alu_busA[31]);
         end
         5'h04: begin
            alu_t = {1'b0, alu_busA} - {1'b0, alu_busB};
            alu_res = alu_t[31:0];
            alu_c = alu_t[32];
            alu_v = (alu_busA[31] != alu_busB[31]) && (alu_res[31] != alu_busA[31]);
         end
         5'h05: alu_res = alu_busA & alu_busB;
         5'h06: alu_res = alu_busA | alu_busB;
         5'h07: alu_res = alu_busA ^ alu_busB;
         5'h08: alu_res = ~alu_busA;
         5'h09: begin alu_res = alu_busA << 1; alu_c = alu_busA[31]; end
         5'h0A: begin alu_res = alu_busA >> 1; alu_c = alu_busA[0]; end
         default: begin alu_res = 32'hDEAD_BEEF; alu_known = 1'b0; end
      endcase
      alu_result = alu_res;
      alu_flags = alu_known ? {(alu_res == 32'd0), alu_res[31], alu_c, alu_v} : 4'b1111;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op);
      if (p == 0) begin
         req_a[31:0] = a; req_b[31:0] = b; req_op[4:0] = op; req_valid[0] = 1'b1;
      end else begin
         req_a[63:32] = a; req_b[63:32] = b; req_op[9:5] = op; req_valid[1] = 1'b1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
      checks++; if (rsp_result !== 32'd0 || rsp_flags !== 4'd0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp: got %h/%b/%b expected 0/0000/0", rsp_result, rsp_flags, rsp_err); end
      checks++; if (alu_operation !== 5'h00 || alu_busA !== 32'd0 || alu_busB !== 32'd0) begin errors++; $display("FAIL reset_alu: got op %h a %h b %h expected all 0", alu_operation, alu_busA, alu_busB); end
      checks++; if (ops_done !== 16'd0) begin errors++; $display("FAIL reset_ops_done: got %0d expected 0", ops_done); end
   endtask

   task automatic test_port0_add();
      set_port(0, 32'd2, 32'd5, 5'h03);
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL add0_req_ready: got %b expected 01", req_ready); end
      tick();
      req_valid = 2'b00;
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL add0_exec_rsp_valid: got %b expected 00", rsp_valid); end
      checks++; if (alu_operation !== 5'h03 || alu_busA !== 32'd2 || alu_busB !== 32'd5) begin errors++; $display("FAIL add0_exec_alu: got op %h a %h b %h expected 03/2/5", alu_operation, alu_busA, alu_busB); end
      tick();
      checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL add0_latency: got rsp_valid %b expected 01", rsp_valid); end
      checks++; if (rsp_result !== 32'd7 || rsp_flags !== 4'b0000 || rsp_err !== 1'b0) begin errors++; $display("FAIL add0_rsp: got %h/%b/%b expected 7/0000/0", rsp_result, rsp_flags, rsp_err); end
      rsp_ready = 2'b01;
      tick();
      rsp_ready = 2'b00;
      checks++; if (rsp_valid !== 2'b00 || ops_done !== 16'd1) begin errors++; $display("FAIL add0_done: got rsp_valid %b ops %0d expected 00/1", rsp_valid, ops_done); end
   endtask

   task automatic test_port1_overflow();
      set_port(1, 32'h7FFF_FFFF, 32'd1, 5'h03);
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL ovf_req_ready: got %b expected 10", req_ready); end
      tick();
      req_valid = 2'b00;
      tick();
      checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL ovf_rsp_valid: got %b expected 10", rsp_valid); end
      checks++; if (rsp_result !== 32'h8000_0000 || rsp_flags !== 4'b0101) begin errors++; $display("FAIL ovf_rsp: got %h/%b expected 80000000/0101", rsp_result, rsp_flags); end
      rsp_ready = 2'b10;
      tick();
      rsp_ready = 2'b00;
   endtask

   task automatic test_both_from_reset();
      do_reset();
      set_port(0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'h05);
      set_port(1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'h06);
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL tie_first_grant: got %b expected 01", req_ready); end
      tick();
      req_valid[0] = 1'b0;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL tie_exec_ready: got %b expected 00", req_ready); end
      tick();
      checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd0 || rsp_flags !== 4'b1000) begin errors++; $display("FAIL tie_and_rsp: got %b %h %b expected 01 0 1000", rsp_valid, rsp_result, rsp_flags); end
      rsp_ready = 2'b01;
      tick();
      rsp_ready = 2'b00;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL tie_second_grant: got %b expected 10", req_ready); end
      tick();
      req_valid = 2'b00;
      tick();
      checks++; if (rsp_valid !== 2'b10 || rsp_result !== 32'hFFFF_FFFF || rsp_flags !== 4'b0100) begin errors++; $display("FAIL tie_or_rsp: got %b %h %b expected 10 ffffffff 0100", rsp_valid, rsp_result, rsp_flags); end
      rsp_ready = 2'b10;
      tick();
      rsp_ready = 2'b00;
      checks++; if (ops_done !== 16'd2) begin errors++; $display("FAIL tie_ops_done: got %0d expected 2", ops_done); end
   endtask

   task automatic test_alternate();
      logic [1:0]  exp_grant [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
      logic [31:0] exp_res   [4] = '{32'd2, 32'd20, 32'd2, 32'd20};
      do_reset();
      set_port(0, 32'd1, 32'd1, 5'h03);
      set_port(1, 32'd10, 32'd10, 5'h03);
      #1;
      for (int i = 0; i < 4; i++) begin
         int n = 0;
         while (req_ready === 2'b00 && n < 10) begin tick(); n++; end
         checks++; if (req_ready !== exp_grant[i]) begin errors++; $display("FAIL rr_grant_%0d: got %b expected %b", i, req_ready, exp_grant[i]); end
         tick();
         tick();
         checks++; if (rsp_valid !== exp_grant[i] || rsp_result !== exp_res[i]) begin errors++; $display("FAIL rr_rsp_%0d: got %b %h expected %b %h", i, rsp_valid, rsp_result, exp_grant[i], exp_res[i]); end
         rsp_ready = 2'b11;
         tick();
         rsp_ready = 2'b00;
      end
      req_valid = 2'b00;
      checks++; if (ops_done !== 16'd4) begin errors++; $display("FAIL rr_ops_done: got %0d expected 4", ops_done); end
   endtask

   task automatic test_rsp_stall();
      set_port(0, 32'h0000_FF00, 32'h0000_0F0F, 5'h07);
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_grant: got %b expected 01", req_ready); end
      tick();
      req_valid = 2'b00;
      set_port(1, 32'd3, 32'd3, 5'h03);
      tick();
      for (int i = 0; i < 5; i++) begin
         rsp_ready = (i % 2 == 0) ? 2'b10 : 2'b00;
         checks++;
         if (rsp_valid !== 2'b01 || rsp_result !== 32'h0000_F00F || rsp_flags !== 4'b0000 ||
             rsp_err !== 1'b0 || req_ready !== 2'b00 || alu_operation !== 5'h00) begin
            errors++;
            $display("FAIL stall_hold_%0d: got v %b r %h f %b e %b rdy %b op %h expected 01 f00f 0000 0 00 00",
                     i, rsp_valid, rsp_result, rsp_flags, rsp_err, req_ready, alu_operation);
         end
         tick();
      end
      rsp_ready = 2'b01;
      tick();
      rsp_ready = 2'b00;
      checks++; if (ops_done !== 16'd5 || req_ready !== 2'b10) begin errors++; $display("FAIL stall_release: got ops %0d rdy %b expected 5/10", ops_done, req_ready); end
      req_valid = 2'b00;
      tick();
      checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || alu_operation !== 5'h00 || ops_done !== 16'd5) begin errors++; $display("FAIL withdraw: got rdy %b v %b op %h ops %0d expected 00/00/00/5", req_ready, rsp_valid, alu_operation, ops_done); end
   endtask

   task automatic test_illegal_op();
      set_port(0, 32'd3, 32'd4, 5'h02);
      #1;
      tick();
      req_valid = 2'b00;
      checks++; if (alu_operation !== 5'h00) begin errors++; $display("FAIL illegal_alu_op: got %h expected 00", alu_operation); end
      tick();
      checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_result !== 32'd0 || rsp_flags !== 4'b0000) begin errors++; $display("FAIL illegal_rsp: got v %b e %b r %h f %b expected 01 1 0 0000", rsp_valid, rsp_err, rsp_result, rsp_flags); end
      rsp_ready = 2'b01;
      tick();
      rsp_ready = 2'b00;
      checks++; if (ops_done !== 16'd6) begin errors++; $display("FAIL illegal_ops_done: got %0d expected 6", ops_done); end
   endtask

   task automatic test_reset_mid_exec();
      set_port(0, 32'h8000_0001, 32'd0, 5'h09);
      #1;
      tick();
      req_valid = 2'b00;
      checks++; if (alu_operation !== 5'h09 || alu_busA !== 32'h8000_0001) begin errors++; $display("FAIL midrst_exec: got op %h a %h expected 09/80000001", alu_operation, alu_busA); end
      rst = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 2'b00 || req_ready !== 2'b00 || rsp_result !== 32'd0 || rsp_flags !== 4'd0 ||
          rsp_err !== 1'b0 || alu_operation !== 5'h00 || alu_busA !== 32'd0 || alu_busB !== 32'd0 ||
          ops_done !== 16'd0) begin
         errors++;
         $display("FAIL midrst_values: got v %b rdy %b r %h f %b e %b op %h a %h b %h ops %0d expected all 0",
                  rsp_valid, req_ready, rsp_result, rsp_flags, rsp_err, alu_operation, alu_busA, alu_busB, ops_done);
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL midrst_no_rsp_%0d: got %b expected 00", i, rsp_valid); end
      end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      req_a = 64'd0;
      req_b = 64'd0;
      req_op = 10'd0;
      test_reset();
      test_port0_add();
      test_port1_overflow();
      test_both_from_reset();
      test_alternate();
      test_rsp_stall();
      test_illegal_op();
      test_reset_mid_exec();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
